// File: rtl/spike_decoder.sv
// Spike-count classifier: synchronizes four-phase request/ack channels from the last layer,
// counts spikes per neuron over a fixed window, then picks the busiest neuron by sequential argmax.
module spike_decoder #(
  parameter int neurons       = 4,
  parameter int cnt_bits      = 8,
  parameter int window_cycles = 1000,
  parameter int sync_stages   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [neurons-1:0]         req_in,
  output logic [neurons-1:0]         ack_in,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(neurons)-1:0] class_out,
  output logic [cnt_bits-1:0]        max_count
);

  localparam int IW = $clog2(neurons);
  localparam int WW = (window_cycles > 1) ? $clog2(window_cycles) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_COMPARE, S_DONE} state_t;

  state_t              state;
  logic [WW-1:0]       win;
  logic [IW-1:0]       idx, best_idx, nxt_idx;
  logic [cnt_bits-1:0] best_cnt, nxt_cnt;
  logic [cnt_bits-1:0] cnt [neurons];
  logic                clr, counting;

  assign clr      = (state == S_IDLE) && start;
  assign counting = (state == S_COUNT);

  // Per-channel handshake: ack simply mirrors the synchronized request, so a spike is the
  // cycle where the synchronized request is high but the ack has not caught up yet.
  for (genvar g = 0; g < neurons; g++) begin : g_lane
    logic [sync_stages-1:0] sq;
    logic                   ack_q;
    logic [cnt_bits-1:0]    c;
    logic                   spike;

    assign spike     = sq[sync_stages-1] & ~ack_q;
    assign ack_in[g] = ack_q;
    assign cnt[g]    = c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sq    <= '0;
        ack_q <= 1'b0;
        c     <= '0;
      end else begin
        sq    <= {sq[sync_stages-2:0], req_in[g]};
        ack_q <= sq[sync_stages-1];
        if (clr)
          c <= '0;
        else if (counting && spike && (c != '1))
          c <= c + 1'b1;
      end
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    nxt_cnt = best_cnt;
    nxt_idx = best_idx;
    if (cnt[idx] > best_cnt) begin
      nxt_cnt = cnt[idx];
      nxt_idx = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      max_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_COUNT;
          win   <= '0;
          busy  <= 1'b1;
        end
        S_COUNT: begin
          win <= win + 1'b1;
          if (win == WW'(window_cycles - 1)) begin
            state    <= S_COMPARE;
            idx      <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        S_COMPARE: begin
          best_cnt <= nxt_cnt;
          best_idx <= nxt_idx;
          idx      <= idx + 1'b1;
          if (idx == IW'(neurons - 1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            class_out <= nxt_idx;
            max_count <= nxt_cnt;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Bench for spike_decoder: directed handshake/classification scenarios plus random four-phase
// traffic, all compared each cycle against a queue/array model of the classifier.
module tb_spike_decoder;
  localparam int N    = 4;
  localparam int CB   = 4;
  localparam int W    = 200;
  localparam int SS   = 2;
  localparam int MAXC = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [N-1:0]  req_in, ack_in;
  logic          busy, done;
  logic [1:0]    class_out;
  logic [CB-1:0] max_count;

  always #5 clk = ~clk;

  spike_decoder #(.neurons(N), .cnt_bits(CB), .window_cycles(W), .sync_stages(SS)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .start(start),
    .busy(busy), .done(done), .class_out(class_out), .max_count(max_count)
  );

  int n_pass = 0, n_chk = 0, ecount = 0, n_done = 0, start_edge = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Model: ack is the request seen SS edges earlier; spikes are ack rising edges;
  // a window counts spikes on edges 1..W after start, result at W+N, done pulse after W+N+1.
  logic [N-1:0] m_q[$];
  logic [N-1:0] m_ack, m_new, m_ev;
  int  m_cnt[N];
  int  m_t, m_class, m_max;
  bit  m_run, m_busy, m_done, m_ok = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      for (int k = 0; k < SS; k++) m_q.push_back('0);
      m_ack = '0; m_run = 0; m_busy = 0; m_done = 0;
      m_class = 0; m_max = 0; m_t = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      m_new = m_q.pop_front();
      m_q.push_back(req_in);
      m_ev  = m_new & ~m_ack;
      m_ack = m_new;
      m_done = 0;
      if (m_run) begin
        m_t++;
        if (m_t <= W)
          for (int i = 0; i < N; i++)
            if (m_ev[i] && m_cnt[i] < MAXC) m_cnt[i]++;
        if (m_t == W + N) begin
          m_busy = 0; m_class = 0; m_max = 0;
          for (int i = 0; i < N; i++)
            if (m_cnt[i] > m_max) begin m_max = m_cnt[i]; m_class = i; end
        end
        if (m_t == W + N + 1) begin m_done = 1; m_run = 0; end
      end else if (start) begin
        m_run = 1; m_t = 0; m_busy = 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_ok) begin
      n_chk++;
      if (ack_in === m_ack && busy === m_busy && done === m_done &&
          class_out === 2'(m_class) && max_count === CB'(m_max))
        n_pass++;
      else
        $display("FAIL model_cmp t=%0t: ack %b want %b, busy %b want %b, done %b want %b, class %0d want %0d, max %0d want %0d",
                 $time, ack_in, m_ack, busy, m_busy, done, m_done, class_out, m_class, max_count, m_max);
      if (done === 1'b1) n_done++;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic spike(logic [N-1:0] m, int n);
    repeat (n) begin
      req_in = req_in | m;  tick(4);
      req_in = req_in & ~m; tick(4);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1 start_edge = ecount;
    @(negedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < W + N + 50; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = ecount - start_edge; break; end
    end
    #2;
  endtask

  task automatic edges_until(int ch, logic val, output int e);
    e = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ack_in[ch] === val) begin e = k; break; end
    end
    @(negedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, e, d0;
    rst = 1'b0; start = 1'b0; req_in = '0;
    #3 rst = 1'b1; #1;
    check("reset_outputs", int'({ack_in, busy, done, class_out, max_count}), 0);
    tick(2); rst = 1'b0; tick(2);

    // handshake latency on channel 1
    req_in[1] = 1'b1; edges_until(1, 1'b1, e);
    check("ack1_rise_edges", e, 3);
    check("other_acks_low", int'(ack_in & 4'b1101), 0);
    req_in[1] = 1'b0; edges_until(1, 1'b0, e);
    check("ack1_fall_edges", e, 3);
    tick(3);

    // classification: ch3 spikes before start are discarded
    spike(4'b1000, 2); tick(4);
    do_start();
    fork
      spike(4'b0001, 3);
      spike(4'b0100, 5);
    join
    wait_done(lat);
    check("class_latency", lat, W + N + 1);
    check("class_idx", int'(class_out), 2);
    check("class_max", int'(max_count), 5);

    // asynchronous reset mid-cycle with an ack high and a result held
    req_in = 4'b0001; tick(5);
    #1 rst = 1'b1; #1;
    check("async_rst_outputs", int'({ack_in, busy, done, class_out, max_count}), 0);
    tick(1); rst = 1'b0; req_in = '0; tick(6);

    // tie with simultaneous requests
    do_start(); spike(4'b1010, 4); wait_done(lat);
    check("tie_idx", int'(class_out), 1);
    check("tie_max", int'(max_count), 4);

    // saturation
    do_start(); spike(4'b0001, 20); wait_done(lat);
    check("sat_max", int'(max_count), MAXC);
    check("sat_idx", int'(class_out), 0);

    // stray start during COUNT
    d0 = n_done;
    do_start(); tick(30); start = 1'b1; tick(1); start = 1'b0;
    wait_done(lat);
    check("stray_start_latency", lat, W + N + 1);
    tick(10);
    check("single_done", n_done - d0, 1);

    // reset during COUNT with ch2 mid-handshake
    do_start(); req_in[2] = 1'b1; tick(6);
    check("ack2_high", int'(ack_in[2]), 1);
    check("busy_in_count", int'(busy), 1);
    #1 rst = 1'b1; #1;
    check("rst_ack2_low", int'(ack_in[2]), 0);
    check("rst_busy_low", int'(busy), 0);
    tick(1); rst = 1'b0;
    edges_until(2, 1'b1, e);
    check("ack2_rerise_edges", e, 3);
    req_in = '0; tick(6);

    // random four-phase traffic with random starts and one reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++)
        if (req_in[i] === ack_in[i] && $urandom_range(2) == 0) req_in[i] = ~req_in[i];
      start = ($urandom_range(15) == 0);
      rst   = (cyc == 1700);
      tick(1);
    end
    rst = 1'b0; start = 1'b0; req_in = '0; tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
